// File: rtl/regfile_port_scheduler.sv
// regfile_port_scheduler: owns the 32x8 register file ports, clears it after reset and
// arbitrates single-register debug accesses against the pipeline with bounded starvation.
module regfile_port_scheduler #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [4:0] pipe_rs1,
  input  logic [4:0] pipe_rs2,
  input  logic [4:0] pipe_rd,
  input  logic [7:0] pipe_wdata,
  input  logic       pipe_we,
  output logic       pipe_stall,
  output logic       init_done,
  input  logic       dbg_req,
  input  logic       dbg_we,
  input  logic [4:0] dbg_addr,
  input  logic [7:0] dbg_wdata,
  output logic       dbg_gnt,
  output logic       dbg_rvalid,
  output logic [7:0] dbg_rdata,
  output logic [4:0] rf_read_reg1,
  output logic [4:0] rf_read_reg2,
  output logic [4:0] rf_write_reg,
  output logic [7:0] rf_write_data,
  output logic       rf_reg_write,
  input  logic [7:0] rf_read_data1
);
  typedef enum logic [1:0] {CLEAR, RUN, DBG_ACC, DBG_RD} state_t;
  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);
  state_t state, state_n;
  logic [4:0] clr_idx, l_addr;
  logic [3:0] wait_cnt, wait_n;
  logic [7:0] l_wdata;
  logic l_we, take, wr;
  always_comb begin
    take = state == RUN && dbg_req && (!pipe_we || wait_cnt == LIM);
    state_n = state;
    wait_n = wait_cnt;
    rf_read_reg1 = '0;
    rf_read_reg2 = '0;
    rf_write_reg = '0;
    rf_write_data = '0;
    wr = 1'b0;
    pipe_stall = 1'b1;
    dbg_gnt = 1'b0;
    case (state)
      CLEAR: begin
        rf_write_reg = clr_idx;
        wr = 1'b1;
        state_n = clr_idx == 5'd31 ? RUN : CLEAR;
      end
      RUN: begin
        rf_read_reg1 = pipe_rs1;
        rf_read_reg2 = pipe_rs2;
        rf_write_reg = pipe_rd;
        rf_write_data = pipe_wdata;
        wr = pipe_we && pipe_rd != '0;
        pipe_stall = 1'b0;
        state_n = take ? DBG_ACC : RUN;
        wait_n = (!dbg_req || take) ? '0 : (wait_cnt == LIM ? wait_cnt : wait_cnt + 4'd1);
      end
      DBG_ACC: begin
        dbg_gnt = 1'b1;
        rf_read_reg1 = l_addr;
        rf_write_reg = l_addr;
        rf_write_data = l_wdata;
        wr = l_we && l_addr != '0;
        state_n = l_we ? RUN : DBG_RD;
      end
      DBG_RD: begin
        rf_read_reg1 = l_addr;
        state_n = RUN;
      end
      default: state_n = CLEAR;
    endcase
    rf_reg_write = reset && wr;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= CLEAR;
      clr_idx <= '0;
      wait_cnt <= '0;
      init_done <= 1'b0;
      dbg_rvalid <= 1'b0;
      dbg_rdata <= '0;
      l_addr <= '0;
      l_we <= 1'b0;
      l_wdata <= '0;
    end else begin
      state <= state_n;
      wait_cnt <= wait_n;
      clr_idx <= state == CLEAR ? clr_idx + 5'd1 : clr_idx;
      init_done <= init_done || (state == CLEAR && clr_idx == 5'd31);
      dbg_rvalid <= state == DBG_RD;
      if (state == DBG_RD) dbg_rdata <= rf_read_data1;
      if (take) begin
        l_addr <= dbg_addr;
        l_we <= dbg_we;
        l_wdata <= dbg_wdata;
      end
    end
  end
endmodule

// File: tb/tb_regfile_port_scheduler.sv
// tb_regfile_port_scheduler: closes the loop with a behavioural register file and
// scoreboards pipeline and debug reads against a bench-side register image.
module tb_regfile_port_scheduler;
  localparam int SL = 4;
  logic clock = 1'b0, reset = 1'b0;
  logic [4:0] pipe_rs1 = '0, pipe_rs2 = '0, pipe_rd = '0, dbg_addr = '0;
  logic [7:0] pipe_wdata = '0, dbg_wdata = '0;
  logic pipe_we = 1'b0, dbg_req = 1'b0, dbg_we = 1'b0, rd_chk = 1'b0;
  logic pipe_stall, init_done, dbg_gnt, dbg_rvalid, rf_reg_write;
  logic [7:0] dbg_rdata, rf_write_data, rf_read_data1;
  logic [4:0] rf_read_reg1, rf_read_reg2, rf_write_reg;
  logic [7:0] mem [32];
  logic [7:0] exp_rf [32];
  logic [7:0] pexp [$];
  logic [7:0] dexp [$];
  int vectors = 0, errs = 0;
  always #5 clock = ~clock;
  regfile_port_scheduler #(.STARVE_LIMIT(SL)) dut (
    .clock(clock), .reset(reset),
    .pipe_rs1(pipe_rs1), .pipe_rs2(pipe_rs2), .pipe_rd(pipe_rd), .pipe_wdata(pipe_wdata),
    .pipe_we(pipe_we), .pipe_stall(pipe_stall), .init_done(init_done),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .rf_read_reg1(rf_read_reg1), .rf_read_reg2(rf_read_reg2), .rf_write_reg(rf_write_reg),
    .rf_write_data(rf_write_data), .rf_reg_write(rf_reg_write), .rf_read_data1(rf_read_data1)
  );
  always @(posedge clock) begin
    if (rf_reg_write) mem[rf_write_reg] <= rf_write_data;
    rf_read_data1 <= mem[rf_read_reg1];
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // Scoreboard: reads are pushed in the cycle they are issued and popped when data returns.
  always @(negedge clock) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) exp_rf[i] = '0;
      pexp.delete();
      dexp.delete();
    end else begin
      if (pexp.size() != 0) chk("pipe_rd", rf_read_data1, pexp.pop_front());
      if (dbg_rvalid) begin
        if (dexp.size() == 0) chk("rv_unexp", 1, 0);
        else chk("dbg_rd", dbg_rdata, dexp.pop_front());
      end
      if (dbg_gnt || dbg_rvalid) chk("gnt_rv_excl", dbg_gnt && dbg_rvalid, 0);
      if (rd_chk && !pipe_stall) pexp.push_back(exp_rf[pipe_rs1]);
      if (!pipe_stall && pipe_we && pipe_rd != '0) exp_rf[pipe_rd] = pipe_wdata;
      if (dbg_gnt && !dbg_we) dexp.push_back(exp_rf[dbg_addr]);
      if (dbg_gnt && dbg_we && dbg_addr != '0) exp_rf[dbg_addr] = dbg_wdata;
    end
  end
  task automatic nxt();
    @(posedge clock);
    #1;
  endtask
  task automatic clear_chk();
    for (int i = 0; i < 32; i++) begin
      @(negedge clock);
      chk("clr_we", rf_reg_write, 1);
      chk("clr_reg", rf_write_reg, i);
      chk("clr_dat", rf_write_data, 0);
      chk("clr_stall", pipe_stall, 1);
      chk("clr_done", init_done, 0);
    end
    @(negedge clock);
    chk("init_done", init_done, 1);
    chk("run_stall", pipe_stall, 0);
    nxt();
  endtask
  task automatic pread(input logic [4:0] a);
    pipe_we = 1'b0;
    pipe_rs1 = a;
    rd_chk = 1'b1;
    nxt();
    rd_chk = 1'b0;
  endtask
  task automatic dbg_access(input logic we, input logic [4:0] a, input logic [7:0] d);
    int n;
    n = 0;
    dbg_req = 1'b1;
    dbg_we = we;
    dbg_addr = a;
    dbg_wdata = d;
    @(negedge clock);
    while (!dbg_gnt && n < 20) begin
      n++;
      nxt();
      @(negedge clock);
    end
    chk("gnt_wait", 32'(n), 1);
    if (!dbg_gnt) begin
      dbg_req = 1'b0;
      return;
    end
    chk("acc_stall", pipe_stall, 1);
    chk("acc_we", rf_reg_write, we && a != '0);
    chk("acc_wreg", rf_write_reg, a);
    chk("acc_rreg", rf_read_reg1, a);
    chk("acc_rreg2", rf_read_reg2, 0);
    nxt();
    dbg_req = 1'b0;
    @(negedge clock);
    if (!we) begin
      chk("rd_stall", pipe_stall, 1);
      chk("rd_we", rf_reg_write, 0);
      chk("rd_gnt", dbg_gnt, 0);
      nxt();
      @(negedge clock);
      chk("rvalid", dbg_rvalid, 1);
    end
    chk("post_stall", pipe_stall, 0);
    nxt();
  endtask
  initial begin
    int gk, cnt;
    logic acc;
    repeat (3) nxt();
    @(negedge clock);
    chk("rst_stall", pipe_stall, 1);
    chk("rst_done", init_done, 0);
    chk("rst_gnt", dbg_gnt, 0);
    chk("rst_rv", dbg_rvalid, 0);
    chk("rst_rdata", dbg_rdata, 0);
    chk("rst_we", rf_reg_write, 0);
    nxt();
    reset = 1'b1;
    clear_chk();
    pipe_we = 1'b1; pipe_rd = 5'd5; pipe_wdata = 8'hA5; pipe_rs2 = 5'd9;
    @(negedge clock);
    chk("run_we", rf_reg_write, 1);
    chk("run_rreg2", rf_read_reg2, 9);
    nxt();
    pread(5'd5);
    pipe_we = 1'b1; pipe_rd = 5'd0; pipe_wdata = 8'hFF;
    @(negedge clock);
    chk("x0_we", rf_reg_write, 0);
    nxt();
    pread(5'd0);
    pread(5'd5);
    repeat (40) begin
      pipe_we = 1'($urandom);
      pipe_rd = 5'($urandom);
      pipe_wdata = 8'($urandom);
      pipe_rs1 = 5'($urandom);
      pipe_rs2 = 5'($urandom);
      rd_chk = 1'b1;
      nxt();
    end
    rd_chk = 1'b0;
    pipe_we = 1'b0;
    dbg_access(1'b1, 5'd7, 8'h3C);
    dbg_access(1'b0, 5'd7, 8'h00);
    // Pipeline keeps writing every cycle and only advances its writeback when not stalled.
    gk = -1;
    cnt = 0;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd13;
    pipe_we = 1'b1; pipe_rd = 5'd10; pipe_wdata = 8'($urandom);
    for (int k = 0; k < 15; k++) begin
      @(negedge clock);
      acc = !pipe_stall;
      if (dbg_gnt && gk < 0) begin
        gk = k;
        chk("st_we", rf_reg_write, 0);
      end
      nxt();
      if (gk >= 0) dbg_req = 1'b0;
      if (acc) begin
        cnt++;
        pipe_rd = 5'(10 + cnt % 6);
        pipe_wdata = 8'($urandom);
      end
    end
    dbg_req = 1'b0;
    chk("starve", 32'(gk), SL + 1);
    for (int r = 10; r < 16; r++) pread(5'(r));
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd7;
    @(negedge clock);
    nxt();
    @(negedge clock);
    chk("r5_gnt", dbg_gnt, 1);
    nxt();
    dbg_req = 1'b0;
    reset = 1'b0;
    #1;
    chk("r5_rdata", dbg_rdata, 0);
    chk("r5_done", init_done, 0);
    chk("r5_stall", pipe_stall, 1);
    chk("r5_we", rf_reg_write, 0);
    repeat (2) begin
      @(negedge clock);
      chk("r5_rv", dbg_rvalid, 0);
    end
    nxt();
    reset = 1'b1;
    clear_chk();
    pread(5'd7);
    pread(5'd13);
    dbg_access(1'b1, 5'd0, 8'h55);
    dbg_access(1'b0, 5'd0, 8'h00);
    repeat (3) nxt();
    chk("pq_drain", pexp.size(), 0);
    chk("dq_drain", dexp.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
